pixel_loader: RTL and testbench
===============================

Name: pixel_loader

Overview:
- Writer side of the 784-bit image buffer that layer_one reads during s_LAYER_1.
- Accepts the 28x28 binarized MNIST image as a byte stream with a valid/ready handshake while the top-level FSM is in s_LOAD.
- Packs the stream into the flattened pixels vector, indexed pixels[r*28+c], and raises load_done so the top FSM can advance to s_LAYER_1.

Parameters:
- IMG_BITS, 784: image size in bits (28x28).
- BYTE_W, 8: stream word width. IMG_BITS must be divisible by BYTE_W; NUM_BYTES = IMG_BITS/BYTE_W = 98 is a derived localparam.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- state  input  3  top-level FSM state (s_IDLE=000, s_LOAD=001, s_LAYER_1=010, s_LAYER_2=011, s_LAYER_3=100).
- in_data  input  BYTE_W  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- pixels  output  [0:IMG_BITS-1]  packed image, pixels[r*28+c].
- byte_count  output  7  bytes accepted in the current load.
- load_done  output  1  image complete; level signal.
- load_error  output  1  checksum mismatch; tied 0 without the optional feature.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, on rst. Every register is updated only on posedge clk, and rst is sampled there.
- Reset values: pixels all 0, byte_count 0, load_done 0, load_error 0, internal FSM in L_IDLE. in_ready is 0 during and after reset.
- Internal FSM states: L_IDLE, L_FILL, (L_CSUM with the optional feature), L_DONE.
- L_IDLE -> L_FILL on the edge where state==s_LOAD. byte_count is cleared on that edge.
- in_ready is combinational: in_ready = (fsm==L_FILL or fsm==L_CSUM) && state==s_LOAD. It is therefore 0 in the first s_LOAD cycle.
- Transfer: a byte is accepted only on an edge where in_valid && in_ready. in_valid without in_ready has no effect. Throughput is one byte per cycle, and gaps in in_valid are allowed.
- Packing: byte k (0-based) is written to pixels[8k .. 8k+7] MSB-first, so in_data[7] goes to pixels[8k] and in_data[0] to pixels[8k+7].
  - The new bits are visible on pixels the cycle after acceptance.
  - byte_count increments on each accepted byte.
- Completion: the edge accepting byte NUM_BYTES-1 moves the FSM to L_DONE and sets load_done=1 on that same edge, so load_done is visible the next cycle.
- L_DONE:
  - in_ready=0; pixels and byte_count are frozen.
  - load_done holds 1 through s_LOAD and the s_LAYER_* states.
  - L_DONE -> L_IDLE on the edge where state==s_IDLE, which clears load_done, load_error and byte_count.
- Pixel retention: pixels are never cleared except by rst. A new load overwrites them byte by byte.
- Abort: if state leaves s_LOAD while in L_FILL or L_CSUM, the FSM returns to L_IDLE on that edge.
  - in_ready drops combinationally in the same cycle, so no byte is accepted.
  - byte_count is cleared and load_done stays 0.
  - Partially written pixels are retained but are not valid.
- rst mid-load: all registers return to their reset values on that edge, regardless of FSM state.
- byte_count saturation: it never exceeds NUM_BYTES, and extra valid bytes after completion are not accepted.

Optional Feature:
- Macro: PIXEL_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running XOR of all NUM_BYTES pixel bytes; the accumulator is cleared on L_IDLE -> L_FILL.
  - After the last pixel byte, the FSM enters L_CSUM (load_done still 0) and accepts one more byte.
  - On that edge: load_done=1, load_error = (byte != running XOR), and the FSM moves to L_DONE.
  - byte_count does not count the checksum byte; it ends at 98.
- Undefined:
  - L_CSUM and the accumulator do not exist, and load_error is constant 0.
  - Completion timing is exactly as described in Behaviour.

Decomposition:
- Shared package bnn_pkg holds:
  - the top-level state encodings s_IDLE..s_LAYER_3 as a 3-bit typedef;
  - IMG_DIM=28, IMG_BITS=784, L1_MAPS=8, L1_OUT_BITS=1568.
- The loader FSM state typedef stays local to the module.
- No sub-module: the checksum accumulator is a single XOR register and stays inline.

Test Plan:
- Full load:
  - Stimulus: state=s_LOAD, 98 back-to-back bytes with byte k = k.
  - Response: pixels[8k..8k+7] = k MSB-first; byte_count=98; load_done rises the cycle after byte 97; in_ready=0 afterwards.
- Gappy stream:
  - Stimulus: in_valid toggling 1-0-1 every cycle, plus in_valid=1 while state=s_IDLE.
  - Response: only handshaked bytes are counted; load completes after exactly 98 handshakes; in_valid in s_IDLE leaves pixels unchanged.
- Abort:
  - Stimulus: state=s_LOAD, 40 bytes, then state=s_IDLE with in_valid held.
  - Response: in_ready=0 the same cycle; byte_count=0; load_done=0.
  - Follow-up: a subsequent full load completes normally.
- Hold and release:
  - Stimulus: after done, state steps s_LOAD -> s_LAYER_1 -> s_LAYER_3 -> s_IDLE.
  - Response: load_done=1 and pixels stable until s_IDLE, then load_done=0.
- Reset mid-load:
  - Stimulus: rst=1 for one cycle after byte 50.
  - Response: next cycle pixels all 0, byte_count=0, in_ready=0, load_done=0.
- Checksum (macro defined):
  - Stimulus: 98 bytes of 0xA5, then checksum 0x00.
  - Response: load_done=1, load_error=0.
  - Repeat with checksum 0x01: load_error=1.
  - Without the macro: load_done asserts after byte 97 and load_error stays 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN accelerator: top-level FSM encodings and image/layer sizes.
package bnn_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'b000,
    s_LOAD    = 3'b001,
    s_LAYER_1 = 3'b010,
    s_LAYER_2 = 3'b011,
    s_LAYER_3 = 3'b100
  } top_state_t;

  localparam int IMG_DIM     = 28;
  localparam int IMG_BITS    = IMG_DIM * IMG_DIM;
  localparam int L1_MAPS     = 8;
  localparam int L1_OUT_BITS = 1568;

endpackage

// File: rtl/pixel_loader.sv
// Streams the binarized 28x28 image into the flattened pixel buffer read by layer_one.
// Optional trailing checksum byte enabled with PIXEL_LOADER_CHECKSUM_EN.
module pixel_loader
  import bnn_pkg::*;
#(
  parameter int IMG_BITS = 784,
  parameter int BYTE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          state,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [0:IMG_BITS-1] pixels,
  output logic [6:0]          byte_count,
  output logic                load_done,
  output logic                load_error
);

  localparam int         NUM_BYTES = IMG_BITS / BYTE_W;
  localparam int         IDX_W     = $clog2(IMG_BITS);
  localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_FILL = 2'd1,
`ifdef PIXEL_LOADER_CHECKSUM_EN
    L_CSUM = 2'd2,
`endif
    L_DONE = 2'd3
  } load_state_t;

  load_state_t      fsm;
  load_state_t      fsm_next;
  logic             loading;
  logic             accept;
  logic             take_pixel;
  logic             clr_count;
  logic             set_done;
  logic             clr_done;
  logic [IDX_W-1:0] wr_base;

  assign loading = (state == s_LOAD);

`ifdef PIXEL_LOADER_CHECKSUM_EN
  assign in_ready = !rst && ((fsm == L_FILL) || (fsm == L_CSUM)) && loading;
`else
  assign in_ready = !rst && (fsm == L_FILL) && loading;
`endif

  assign accept  = in_valid && in_ready;
  assign wr_base = IDX_W'(byte_count) * IDX_W'(BYTE_W);

`ifdef PIXEL_LOADER_CHECKSUM_EN
  logic              take_csum;
  logic              clr_csum;
  logic [BYTE_W-1:0] csum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= L_IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  // Leaving s_LOAD mid-transfer abandons the load; the partial image is simply left behind.
  always_comb begin
    fsm_next   = fsm;
    take_pixel = 1'b0;
    clr_count  = 1'b0;
    set_done   = 1'b0;
    clr_done   = 1'b0;
`ifdef PIXEL_LOADER_CHECKSUM_EN
    take_csum  = 1'b0;
    clr_csum   = 1'b0;
`endif
    case (fsm)
      L_IDLE: begin
        if (loading) begin
          fsm_next  = L_FILL;
          clr_count = 1'b1;
`ifdef PIXEL_LOADER_CHECKSUM_EN
          clr_csum  = 1'b1;
`endif
        end
      end
      L_FILL: begin
        if (!loading) begin
          fsm_next  = L_IDLE;
          clr_count = 1'b1;
        end else if (accept) begin
          take_pixel = 1'b1;
          if (byte_count == LAST_BYTE) begin
`ifdef PIXEL_LOADER_CHECKSUM_EN
            fsm_next = L_CSUM;
`else
            fsm_next = L_DONE;
            set_done = 1'b1;
`endif
          end
        end
      end
`ifdef PIXEL_LOADER_CHECKSUM_EN
      L_CSUM: begin
        if (!loading) begin
          fsm_next  = L_IDLE;
          clr_count = 1'b1;
        end else if (accept) begin
          take_csum = 1'b1;
          set_done  = 1'b1;
          fsm_next  = L_DONE;
        end
      end
`endif
      L_DONE: begin
        if (state == s_IDLE) begin
          fsm_next  = L_IDLE;
          clr_count = 1'b1;
          clr_done  = 1'b1;
        end
      end
      default: fsm_next = L_IDLE;
    endcase
  end

  // Byte k lands MSB-first in pixels[8k +: 8] because pixels is an ascending vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixels     <= '0;
      byte_count <= '0;
      load_done  <= 1'b0;
    end else begin
      if (clr_count) begin
        byte_count <= '0;
      end else if (take_pixel) begin
        byte_count <= byte_count + 7'd1;
      end
      if (take_pixel) begin
        pixels[wr_base +: BYTE_W] <= in_data;
      end
      if (clr_done) begin
        load_done <= 1'b0;
      end else if (set_done) begin
        load_done <= 1'b1;
      end
    end
  end

`ifdef PIXEL_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum       <= '0;
      load_error <= 1'b0;
    end else begin
      if (clr_csum) begin
        csum <= '0;
      end else if (take_pixel) begin
        csum <= csum ^ in_data;
      end
      if (clr_done) begin
        load_error <= 1'b0;
      end else if (take_csum) begin
        load_error <= (in_data != csum);
      end
    end
  end
`else
  assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_loader.sv
// Self-checking bench for pixel_loader against a byte-array reference model of the image load.
module tb_pixel_loader;
  import bnn_pkg::*;

  localparam int NB = 98;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   state;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [0:783] pixels;
  logic [6:0]   byte_count;
  logic         load_done;
  logic         load_error;

  pixel_loader dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixels     (pixels),
    .byte_count (byte_count),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit       m_busy;
  bit       m_await_csum;
  bit       m_done;
  bit       m_err;
  int       m_cnt;
  bit [7:0] m_xor;
  bit [7:0] m_img [NB];

  task automatic chk(input string tag, input logic [783:0] obs, input logic [783:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:783] exp_pixels();
    logic [0:783] v;
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++)
        v[8*k+j] = m_img[k][7-j];
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] st, input logic hs, input logic [7:0] d);
    if (r) begin
      m_busy = 0; m_await_csum = 0; m_done = 0; m_err = 0; m_cnt = 0;
      foreach (m_img[k]) m_img[k] = 8'h00;
    end else if (!m_busy && !m_done) begin
      if (st == s_LOAD) begin
        m_busy = 1; m_cnt = 0; m_xor = 8'h00;
      end
    end else if (m_busy) begin
      if (st != s_LOAD) begin
        m_busy = 0; m_await_csum = 0; m_cnt = 0;
      end else if (hs) begin
        if (!m_await_csum) begin
          m_img[m_cnt] = d;
          m_xor ^= d;
          m_cnt++;
          if (m_cnt == NB) begin
`ifdef PIXEL_LOADER_CHECKSUM_EN
            m_await_csum = 1;
`else
            m_busy = 0; m_done = 1;
`endif
          end
        end else begin
          m_await_csum = 0; m_busy = 0; m_done = 1; m_err = (d != m_xor);
        end
      end
    end else if (st == s_IDLE) begin
      m_done = 0; m_err = 0; m_cnt = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] st, input logic v, input logic [7:0] d);
    logic exp_ready;
    rst = r; state = st; in_valid = v; in_data = d;
    #1;
    exp_ready = !r && m_busy && (st == s_LOAD);
    chk("in_ready", in_ready, exp_ready);
    model_edge(r, st, v && exp_ready, d);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    chk("byte_count", byte_count, m_cnt);
    chk("load_done", load_done, m_done);
    chk("load_error", load_error, m_err);
    chk("pixels", pixels, exp_pixels());
  endtask

  // mode 0: byte k = k, mode 1: 0xA5, else random; good_csum sends the true XOR as checksum byte
  task automatic load_image(input int mode, input bit gappy, input bit good_csum,
                            input logic [7:0] csum_byte, input int stop_at);
    logic [7:0] d;
    logic       v;
    int         guard = 0;
    while (!m_done && m_cnt < stop_at && guard < 500) begin
      v = gappy ? logic'(guard % 2 == 0) : 1'b1;
      case (mode)
        0:       d = 8'(m_cnt);
        1:       d = 8'hA5;
        default: d = 8'($urandom);
      endcase
      if (m_await_csum) d = good_csum ? m_xor : csum_byte;
      applyStimulus(1'b0, s_LOAD, v, d);
      guard++;
    end
    if (stop_at >= NB) chk("load_complete", load_done, 1'b1);
    else chk("partial_count", byte_count, 7'(stop_at));
  endtask

  task automatic go_idle();
    applyStimulus(1'b0, s_IDLE, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; state = s_IDLE; in_valid = 1'b0; in_data = 8'h00;
    m_xor = 8'h00;
    applyStimulus(1'b1, s_IDLE, 1'b0, 8'h00);
    applyStimulus(1'b1, s_LOAD, 1'b1, 8'hFF);
    chk("reset_ready", in_ready, 1'b0);

    $display("[TB] valid while idle");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, s_IDLE, 1'b1, 8'($urandom));

    $display("[TB] full load, byte k = k");
    load_image(0, 1'b0, 1'b1, 8'h00, NB);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, s_LOAD, 1'b1, 8'($urandom));

    $display("[TB] hold and release");
    applyStimulus(1'b0, s_LAYER_1, 1'b1, 8'h3C);
    applyStimulus(1'b0, s_LAYER_1, 1'b0, 8'h00);
    applyStimulus(1'b0, s_LAYER_3, 1'b1, 8'hC3);
    applyStimulus(1'b0, s_LAYER_3, 1'b0, 8'h00);
    go_idle();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, s_IDLE, 1'b1, 8'($urandom));

    $display("[TB] gappy random load");
    load_image(2, 1'b1, 1'b1, 8'h00, NB);
    go_idle();

    $display("[TB] abort after 40 bytes");
    load_image(2, 1'b0, 1'b1, 8'h00, 40);
    applyStimulus(1'b0, s_IDLE, 1'b1, 8'($urandom));
    applyStimulus(1'b0, s_IDLE, 1'b1, 8'($urandom));
    load_image(2, 1'b0, 1'b1, 8'h00, NB);
    go_idle();

    $display("[TB] reset mid-load");
    load_image(2, 1'b0, 1'b1, 8'h00, 51);
    applyStimulus(1'b1, s_LOAD, 1'b1, 8'($urandom));
    applyStimulus(1'b0, s_IDLE, 1'b1, 8'($urandom));

    $display("[TB] checksum 0x00 over 0xA5 image");
    load_image(1, 1'b0, 1'b0, 8'h00, NB);
    go_idle();
    $display("[TB] checksum 0x01 over 0xA5 image");
    load_image(1, 1'b1, 1'b0, 8'h01, NB);
    applyStimulus(1'b0, s_LAYER_2, 1'b0, 8'h00);
    go_idle();
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
